garage_door_model: RTL and testbench

Behavioural plant model of the garage door mechanism, driven by the controller's motor commands.
- Consumes up_m/dn_m and tracks door position as a cycle counter.
- Produces the up_max/dn_max limit-switch signals the controller consumes.
- Closes the loop in controller testbenches and on-board demo builds; detects illegal motor command combinations.

---
 rtl/garage_door_model_if.sv | 41 ++++
 rtl/garage_door_model.sv | 195 +++++++++++++++++++
 tb/tb_garage_door_model.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/garage_door_model_if.sv
// Motor-command / limit-switch bundle between a door controller and the
// door plant model. Optional obstruction signals exist only when the
// OBSTRUCT_EN macro is defined.
//
// Signalling: there is no valid/ready handshake on this bundle. up_m/dn_m
// are level commands sampled on every rising clk edge; every plant output
// is a registered level that is valid after each edge. An edge with both
// commands high is illegal and latches the plant into its fault state.
interface garage_door_model_if #(
    parameter int POS_W = 8
);
    logic             up_m;
    logic             dn_m;
    logic             up_max;
    logic             dn_max;
    logic [POS_W-1:0] pos;
    logic             moving;
    logic             fault;
`ifdef OBSTRUCT_EN
    logic             obstruct;
    logic             blocked;
`endif

    // Controller side: drives motor commands, observes the plant.
`ifdef OBSTRUCT_EN
    modport master (output up_m, dn_m, obstruct,
                    input  up_max, dn_max, pos, moving, fault, blocked);
`else
    modport master (output up_m, dn_m,
                    input  up_max, dn_max, pos, moving, fault);
`endif

    // Plant side: samples motor commands, drives limit switches and status.
`ifdef OBSTRUCT_EN
    modport slave  (input  up_m, dn_m, obstruct,
                    output up_max, dn_max, pos, moving, fault, blocked);
`else
    modport slave  (input  up_m, dn_m,
                    output up_max, dn_max, pos, moving, fault);
`endif
endinterface

// File: rtl/garage_door_model.sv
// Behavioural plant model of a garage door. Tracks door position as a count
// of motor-drive cycles (0 = closed, TRAVEL_CYCLES = open), produces the
// limit switches, forces a stationary pause when the motor reverses
// mid-travel and latches a fault on an illegal up+down command.
// Optional feature macro: OBSTRUCT_EN (obstruction input stalls closing).
module garage_door_model #(
    parameter int TRAVEL_CYCLES = 16,
    parameter int POS_W         = 8,
    parameter int REV_DELAY     = 2
) (
    input  logic               clk,
    input  logic               rst,
    garage_door_model_if.slave bus,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MV_UP    = 3'd1,
        MV_DN    = 3'd2,
        REV_WAIT = 3'd3,
        FAULT    = 3'd4
    } state_t;

    localparam logic [POS_W-1:0] TOP      = POS_W'(TRAVEL_CYCLES);
    localparam int               CNT_W    = (REV_DELAY < 1) ? 1 : $clog2(REV_DELAY + 1);
    localparam logic [CNT_W-1:0] REV_LAST = CNT_W'(REV_DELAY);

    state_t           r_state;
    logic [POS_W-1:0] r_pos;
    logic             r_up_max;
    logic             r_dn_max;
    logic             r_moving;
    logic             r_fault;
    logic [CNT_W-1:0] r_rev_cnt;
    logic             r_rev_up;   // direction the pending reversal will travel
`ifdef OBSTRUCT_EN
    logic             r_blocked;
`endif

    logic             w_up_cmd;
    logic             w_dn_cmd;
    logic             w_both;
    logic [POS_W-1:0] w_pos_inc;
    logic [POS_W-1:0] w_pos_dec;
    logic             w_inc_top;
    logic             w_dec_bot;
    logic             w_rev_match;
    logic             w_launch;

    assign w_up_cmd  = bus.up_m & ~bus.dn_m;
    assign w_dn_cmd  = bus.dn_m & ~bus.up_m;
    assign w_both    = bus.up_m & bus.dn_m;
    assign w_pos_inc = r_pos + POS_W'(1);
    assign w_pos_dec = r_pos - POS_W'(1);
    // Limit flags of the next position, so switches change with pos
    assign w_inc_top = (w_pos_inc == TOP);
    assign w_dec_bot = (w_pos_dec == '0);

    // A finished reversal pause launches exactly like a fresh start from IDLE
    assign w_rev_match = r_rev_up ? w_up_cmd : w_dn_cmd;
    assign w_launch    = (r_state == IDLE) ||
                         ((r_state == REV_WAIT) && w_rev_match && (r_rev_cnt >= REV_LAST));

    // Door FSM: position, limit switches and status flags all registered here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_pos     <= '0;
            r_up_max  <= 1'b0;
            r_dn_max  <= 1'b1;
            r_moving  <= 1'b0;
            r_fault   <= 1'b0;
            r_rev_cnt <= '0;
            r_rev_up  <= 1'b0;
`ifdef OBSTRUCT_EN
            r_blocked <= 1'b0;
`endif
        end else begin
            r_moving <= 1'b0;
`ifdef OBSTRUCT_EN
            r_blocked <= 1'b0;
`endif
            if (r_state == FAULT) begin
                // Frozen until reset; limits keep reflecting held pos
                r_state <= FAULT;
            end else if (w_both) begin
                r_state <= FAULT;
                r_fault <= 1'b1;
            end else if (w_launch) begin
                if (w_up_cmd && (r_pos != TOP)) begin
                    r_pos    <= w_pos_inc;
                    r_up_max <= w_inc_top;
                    r_dn_max <= 1'b0;
                    r_moving <= ~w_inc_top;
                    r_state  <= w_inc_top ? IDLE : MV_UP;
                end else if (w_dn_cmd && (r_pos != '0)) begin
                    r_pos    <= w_pos_dec;
                    r_dn_max <= w_dec_bot;
                    r_up_max <= 1'b0;
                    r_moving <= ~w_dec_bot;
                    r_state  <= w_dec_bot ? IDLE : MV_DN;
                end else begin
                    // No command, or command toward a limit already reached
                    r_state <= IDLE;
                end
            end else begin
                case (r_state)
                    MV_UP: begin
                        if (w_up_cmd) begin
                            r_pos    <= w_pos_inc;
                            r_up_max <= w_inc_top;
                            r_dn_max <= 1'b0;
                            r_moving <= ~w_inc_top;
                            r_state  <= w_inc_top ? IDLE : MV_UP;
                        end else if (w_dn_cmd) begin
                            if (REV_DELAY > 0) begin
                                r_state   <= REV_WAIT;
                                r_rev_up  <= 1'b0;
                                r_rev_cnt <= CNT_W'(1);
                            end else begin
                                r_pos    <= w_pos_dec;
                                r_dn_max <= w_dec_bot;
                                r_up_max <= 1'b0;
                                r_moving <= ~w_dec_bot;
                                r_state  <= w_dec_bot ? IDLE : MV_DN;
                            end
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    MV_DN: begin
                        if (w_dn_cmd) begin
`ifdef OBSTRUCT_EN
                            if (bus.obstruct) begin
                                // Stall closing in place; stay in MV_DN
                                r_blocked <= 1'b1;
                            end else begin
                                r_pos    <= w_pos_dec;
                                r_dn_max <= w_dec_bot;
                                r_up_max <= 1'b0;
                                r_moving <= ~w_dec_bot;
                                r_state  <= w_dec_bot ? IDLE : MV_DN;
                            end
`else
                            r_pos    <= w_pos_dec;
                            r_dn_max <= w_dec_bot;
                            r_up_max <= 1'b0;
                            r_moving <= ~w_dec_bot;
                            r_state  <= w_dec_bot ? IDLE : MV_DN;
`endif
                        end else if (w_up_cmd) begin
                            if (REV_DELAY > 0) begin
                                r_state   <= REV_WAIT;
                                r_rev_up  <= 1'b1;
                                r_rev_cnt <= CNT_W'(1);
                            end else begin
                                r_pos    <= w_pos_inc;
                                r_up_max <= w_inc_top;
                                r_dn_max <= 1'b0;
                                r_moving <= ~w_inc_top;
                                r_state  <= w_inc_top ? IDLE : MV_UP;
                            end
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    REV_WAIT: begin
                        if (!w_up_cmd && !w_dn_cmd) begin
                            r_state <= IDLE;
                        end else if (!w_rev_match) begin
                            // Command flipped again: pause restarts toward the new direction
                            r_rev_up  <= ~r_rev_up;
                            r_rev_cnt <= CNT_W'(1);
                        end else begin
                            r_rev_cnt <= r_rev_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign bus.pos    = r_pos;
    assign bus.up_max = r_up_max;
    assign bus.dn_max = r_dn_max;
    assign bus.moving = r_moving;
    assign bus.fault  = r_fault;
`ifdef OBSTRUCT_EN
    assign bus.blocked = r_blocked;
`endif
    assign o_state = r_state;

endmodule

// File: tb/tb_garage_door_model.sv
// Bench for garage_door_model: directed scenarios plus randomized commands,
// each checked against a travel/pause model of the door kept here.
module tb_garage_door_model;

    localparam int TRAVEL_CYCLES = 16;
    localparam int POS_W         = 8;
    localparam int REV_DELAY     = 2;
`ifdef OBSTRUCT_EN
    localparam int VW = POS_W + 5;
`else
    localparam int VW = POS_W + 4;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    garage_door_model_if #(.POS_W(POS_W)) bus();

    garage_door_model #(
        .TRAVEL_CYCLES(TRAVEL_CYCLES),
        .POS_W(POS_W),
        .REV_DELAY(REV_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .o_state(dbg_state)
    );

    // Clock and counters
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [VW-1:0] exp_q[$];

    // Reference model: door position plus current travel direction and an
    // optional pending-reversal pause (remaining stationary edges).
    int m_pos;
    int m_dir;
    int m_hold;
    bit m_waiting;
    bit m_fault;
    bit m_moving;
    bit m_blocked;

    task automatic model_reset();
        m_pos = 0; m_dir = 0; m_hold = 0;
        m_waiting = 0; m_fault = 0; m_moving = 0; m_blocked = 0;
    endtask

    task automatic model_step(input bit u, input bit d, input bit o);
        int cmd;
        bit closing;
        closing   = (m_dir == -1) && !m_waiting;
        m_blocked = 0;
        m_moving  = 0;
        if (m_fault) return;
        if (u && d) begin
            m_fault = 1; m_dir = 0; m_waiting = 0;
            return;
        end
        cmd = u ? 1 : (d ? -1 : 0);
        if (m_waiting) begin
            if (cmd == 0) begin m_waiting = 0; m_dir = 0; return; end
            if (cmd != m_dir) begin m_dir = cmd; m_hold = REV_DELAY - 1; return; end
            if (m_hold > 0) begin m_hold--; return; end
            m_waiting = 0;
        end else if (m_dir != 0 && cmd == -m_dir && REV_DELAY > 0) begin
            m_waiting = 1; m_dir = cmd; m_hold = REV_DELAY - 1;
            return;
        end
        if (cmd == 0) begin m_dir = 0; return; end
        if (cmd == -1 && closing && o) begin m_blocked = 1; return; end
        if ((cmd == 1 && m_pos == TRAVEL_CYCLES) || (cmd == -1 && m_pos == 0)) begin
            m_dir = 0;
            return;
        end
        m_pos = m_pos + cmd;
        if (m_pos == TRAVEL_CYCLES || m_pos == 0) m_dir = 0;
        else begin m_dir = cmd; m_moving = 1; end
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [POS_W-1:0] p;
        p = POS_W'(m_pos);
`ifdef OBSTRUCT_EN
        return {m_blocked, m_fault, m_moving, (m_pos == 0), (m_pos == TRAVEL_CYCLES), p};
`else
        return {m_fault, m_moving, (m_pos == 0), (m_pos == TRAVEL_CYCLES), p};
`endif
    endfunction

    function automatic logic [VW-1:0] obs_vec();
`ifdef OBSTRUCT_EN
        return {bus.blocked, bus.fault, bus.moving, bus.dn_max, bus.up_max, bus.pos};
`else
        return {bus.fault, bus.moving, bus.dn_max, bus.up_max, bus.pos};
`endif
    endfunction

    // Driver: apply a command away from the edge, advance model, sample after edge
    task automatic drive(input bit u, input bit d, input bit o);
        @(negedge clk);
        bus.up_m = u;
        bus.dn_m = d;
`ifdef OBSTRUCT_EN
        bus.obstruct = o;
`endif
        @(posedge clk);
        model_step(u, d, o);
        exp_q.push_back(model_vec());
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (obs_vec() !== model_vec())
            $display("FAIL reset: got %h want %h", obs_vec(), model_vec());
        else
            n_pass++;
        @(negedge clk);
        bus.up_m = 1'b0;
        bus.dn_m = 1'b0;
`ifdef OBSTRUCT_EN
        bus.obstruct = 1'b0;
`endif
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if (bus.pos !== '0 || bus.dn_max !== 1'b1 || bus.up_max !== 1'b0 ||
            bus.moving !== 1'b0 || bus.fault !== 1'b0)
            $display("FAIL reset_const: pos=%0d dn=%b up=%b mv=%b flt=%b want 0 1 0 0 0",
                     bus.pos, bus.dn_max, bus.up_max, bus.moving, bus.fault);
        else
            n_pass++;
    endtask

    task automatic test_open_full();
        logic [VW-1:0] e;
        apply_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if (obs_vec() !== e) $display("FAIL open_full step %0d: got %h want %h", i, obs_vec(), e);
            else n_pass++;
            n_total++;
            if (bus.pos !== POS_W'((i < TRAVEL_CYCLES) ? i + 1 : TRAVEL_CYCLES) ||
                bus.dn_max !== 1'b0 || bus.up_max !== (i >= TRAVEL_CYCLES - 1))
                $display("FAIL open_pos step %0d: pos=%0d up=%b dn=%b", i, bus.pos, bus.up_max, bus.dn_max);
            else n_pass++;
        end
    endtask

    task automatic test_close_full();
        logic [VW-1:0] e;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if (obs_vec() !== e) $display("FAIL close_full step %0d: got %h want %h", i, obs_vec(), e);
            else n_pass++;
        end
        n_total++;
        if (bus.pos !== '0 || bus.dn_max !== 1'b1 || bus.fault !== 1'b0 || bus.moving !== 1'b0)
            $display("FAIL close_end: pos=%0d dn=%b flt=%b mv=%b want 0 1 0 0",
                     bus.pos, bus.dn_max, bus.fault, bus.moving);
        else n_pass++;
    endtask

    task automatic test_reversal();
        logic [VW-1:0] e;
        int want_pos[5] = '{8, 8, 7, 6, 5};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if (obs_vec() !== e) $display("FAIL reversal step %0d: got %h want %h", i, obs_vec(), e);
            else n_pass++;
            n_total++;
            if (bus.pos !== POS_W'(want_pos[i]))
                $display("FAIL reversal_pos step %0d: pos=%0d want %0d", i, bus.pos, want_pos[i]);
            else n_pass++;
        end
    endtask

    task automatic test_fault();
        logic [VW-1:0] e;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
        end
        drive(1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_total++;
        if (bus.fault !== 1'b1 || bus.pos !== POS_W'(5) || obs_vec() !== e)
            $display("FAIL fault_set: flt=%b pos=%0d got %h want %h", bus.fault, bus.pos, obs_vec(), e);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if (bus.pos !== POS_W'(5) || obs_vec() !== e)
                $display("FAIL fault_hold step %0d: pos=%0d got %h want %h", i, bus.pos, obs_vec(), e);
            else n_pass++;
        end
        apply_reset();
    endtask

    task automatic test_limit_idle();
        logic [VW-1:0] e;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if (bus.pos !== '0 || bus.moving !== 1'b0 || bus.fault !== 1'b0 || obs_vec() !== e)
                $display("FAIL limit_idle step %0d: got %h want %h", i, obs_vec(), e);
            else n_pass++;
        end
    endtask

`ifdef OBSTRUCT_EN
    task automatic test_obstruct();
        logic [VW-1:0] e;
        apply_reset();
        for (int i = 0; i < 16; i++) begin drive(1'b1, 1'b0, 1'b0); e = exp_q.pop_front(); end
        for (int i = 0; i < 6; i++)  begin drive(1'b0, 1'b1, 1'b0); e = exp_q.pop_front(); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, (i < 3));
            e = exp_q.pop_front();
            n_total++;
            if (bus.pos !== POS_W'((i < 3) ? 10 : 9) || bus.blocked !== (i < 3) || obs_vec() !== e)
                $display("FAIL obstruct step %0d: pos=%0d blk=%b got %h want %h",
                         i, bus.pos, bus.blocked, obs_vec(), e);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_random();
        logic [VW-1:0] e;
        bit u, d, o;
        int r;
        apply_reset();
        u = 0; d = 0; o = 0;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                u = 1; d = 1;
            end else if (r < 4) begin
                apply_reset();
            end else if (r < 30) begin
                case ($urandom_range(0, 2))
                    0:       begin u = 0; d = 0; end
                    1:       begin u = 1; d = 0; end
                    default: begin u = 0; d = 1; end
                endcase
            end else if (u && d) begin
                u = 0;
            end
`ifdef OBSTRUCT_EN
            o = ($urandom_range(0, 3) == 0);
`endif
            drive(u, d, o);
            e = exp_q.pop_front();
            n_total++;
            if (obs_vec() !== e) $display("FAIL random step %0d: got %h want %h", i, obs_vec(), e);
            else n_pass++;
            if (m_fault && $urandom_range(0, 3) == 0) apply_reset();
        end
    endtask

    // Sequence and final report
    initial begin
        rst = 1'b0;
        bus.up_m = 1'b0;
        bus.dn_m = 1'b0;
`ifdef OBSTRUCT_EN
        bus.obstruct = 1'b0;
`endif
        model_reset();
        test_reset();
        test_open_full();
        test_close_full();
        test_reversal();
        test_fault();
        test_limit_idle();
`ifdef OBSTRUCT_EN
        test_obstruct();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
